// File: rtl/shift_add_pkg.sv
// Shared types for the shift-add / shift-subtract sequencer.
// State encoding and opcode constants.
package shift_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/shift_add_seq_ctrl_iter_counter.sv
// Iteration counter for the shift-add sequencer.
// Synchronous clear, count enable, terminal-count flag at N-1.
module seq_iter_counter #(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == CNT_W'(N - 1));

endmodule

// File: rtl/shift_add_seq_ctrl.sv
// Sequencer for the shared shift-add multiply / shift-subtract divide datapath.
// Optional multiply early termination on rs_zero: SHIFT_ADD_EARLY_TERM_EN.
module shift_add_seq_ctrl
  import shift_add_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = $clog2(N + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic op,
  input  logic b_zero,
  input  logic rs_zero,
  input  logic rem_neg,
  output logic sel_load,
  output logic en_ls,
  output logic en_rs,
  output logic acc_clr,
  output logic acc_en,
  output logic restore,
  output logic q_bit,
  output logic busy,
  output logic finished,
  output logic div0_err
);

  state_e state_q, state_d;
  logic   op_q, op_d;
  logic   dz_q, dz_d;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;
  logic   early;

`ifdef SHIFT_ADD_EARLY_TERM_EN
  assign early = (op_q == OP_MUL) & rs_zero;
`else
  logic unused_rs_zero;
  assign unused_rs_zero = rs_zero;
  assign early = 1'b0;
`endif

  seq_iter_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= OP_MUL;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dz_d     = dz_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    sel_load = 1'b0;
    en_ls    = 1'b0;
    en_rs    = 1'b0;
    acc_clr  = 1'b0;
    acc_en   = 1'b0;
    restore  = 1'b0;
    q_bit    = 1'b0;
    busy     = 1'b0;
    finished = 1'b0;
    div0_err = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op;
          if ((op == OP_DIV) && b_zero) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        sel_load = 1'b1;
        acc_clr  = 1'b1;
        en_ls    = 1'b1;
        en_rs    = 1'b1;
        busy     = 1'b1;
        cnt_clr  = 1'b1;
        state_d  = ITER;
      end
      ITER: begin
        en_ls  = 1'b1;
        en_rs  = 1'b1;
        acc_en = 1'b1;
        busy   = 1'b1;
        if (op_q == OP_DIV) begin
          restore = rem_neg;
          q_bit   = ~rem_neg;
        end
        // Hold at N-1 so the counter never runs past its last value
        cnt_en = ~cnt_tc;
        if (cnt_tc || early) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy     = 1'b1;
        finished = 1'b1;
        div0_err = dz_q;
        dz_d     = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_shift_add_seq_ctrl.sv
// Self-checking bench for shift_add_seq_ctrl.
// Randomized ops checked against a per-cycle phase model.
module tb_shift_add_seq_ctrl;

  localparam int N = 8;

  logic clock = 1'b0;
  logic reset;
  logic start, op, b_zero, rs_zero, rem_neg;
  logic sel_load, en_ls, en_rs, acc_clr, acc_en;
  logic restore, q_bit, busy, finished, div0_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  shift_add_seq_ctrl #(.N(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .b_zero   (b_zero),
    .rs_zero  (rs_zero),
    .rem_neg  (rem_neg),
    .sel_load (sel_load),
    .en_ls    (en_ls),
    .en_rs    (en_rs),
    .acc_clr  (acc_clr),
    .acc_en   (acc_en),
    .restore  (restore),
    .q_bit    (q_bit),
    .busy     (busy),
    .finished (finished),
    .div0_err (div0_err)
  );

  // {sel_load,en_ls,en_rs,acc_clr,acc_en,restore,q_bit,busy,finished,div0_err}
  wire [9:0] obs = {sel_load, en_ls, en_rs, acc_clr, acc_en,
                    restore, q_bit, busy, finished, div0_err};

  // Expected outputs c cycles after the accepting edge of one operation.
  function automatic logic [9:0] model(int c, bit opd, bit dz,
                                       int niter, bit rn);
    if (dz) return (c == 1) ? 10'b0000000111 : 10'b0;
    if (c == 1) return 10'b1111000100;
    if (c <= niter + 1)
      return {4'b0110, 1'b1, opd & rn, opd & ~rn, 3'b100};
    if (c == niter + 2) return 10'b0000000110;
    return 10'b0;
  endfunction

  task automatic run_op(bit opd, bit dz, int rs_iter, bit noise,
                        logic [N-1:0] pat, string tag);
    int niter;
    int last;
    logic [9:0] exp_v;
    niter = N;
`ifdef SHIFT_ADD_EARLY_TERM_EN
    if (!opd && rs_iter >= 1 && rs_iter <= N) niter = rs_iter;
`endif
    last = (opd && dz) ? 2 : niter + 3;
    @(negedge clock);
    start = 1'b1; op = opd; b_zero = dz;
    rs_zero = 1'b0; rem_neg = 1'b0;
    @(negedge clock);
    for (int c = 1; c <= last; c++) begin
      start   = (noise && c < last) ? 1'($urandom) : 1'b0;
      op      = 1'($urandom);
      b_zero  = 1'($urandom);
      rem_neg = (c >= 2 && c <= N + 1) ? pat[c-2] : 1'($urandom);
      rs_zero = (c >= 2) && (c - 1 == rs_iter);
      #1;
      exp_v = model(c, opd, opd && dz, niter, rem_neg);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %b want %b", tag, c, obs, exp_v);
      end
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0; op = 1'b0; b_zero = 1'b0;
    rs_zero = 1'b0; rem_neg = 1'b0;
    #12;
    n_cmp++;
    if (obs !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_hold: got %b want %b", obs, 10'b0);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    #1;
    n_cmp++;
    if (obs !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_release: got %b want %b", obs, 10'b0);
    end
  endtask

  task automatic test_mul();
    run_op(1'b0, 1'b0, 0, 1'b0, N'($urandom), "mul_basic");
    run_op(1'b0, 1'b1, 0, 1'b0, N'($urandom), "mul_bzero_ignored");
  endtask

  task automatic test_div();
    run_op(1'b1, 1'b0, 0, 1'b0, 8'b01001101, "div_pattern");
  endtask

  task automatic test_div0();
    run_op(1'b1, 1'b1, 0, 1'b0, N'($urandom), "div0");
  endtask

  task automatic test_early_term();
    run_op(1'b0, 1'b0, 3, 1'b0, N'($urandom), "mul_early3");
    run_op(1'b1, 1'b0, 3, 1'b0, N'($urandom), "div_rszero");
  endtask

  task automatic test_random();
    bit ro, rd;
    for (int i = 0; i < 20; i++) begin
      ro = 1'($urandom);
      rd = ($urandom_range(0, 3) == 0);
      run_op(ro, rd, $urandom_range(0, N + 2), 1'b1,
             N'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    int p;
    logic [9:0] exp_v;
    @(negedge clock);
    start = 1'b1; op = 1'b0; b_zero = 1'b0;
    rs_zero = 1'b0; rem_neg = 1'b0;
    @(negedge clock);
    for (int c = 1; c <= 22; c++) begin
      if (c == 22) start = 1'b0;
      #1;
      p = (c - 1) % 11 + 1;
      exp_v = (p == 11) ? 10'b0 : model(p, 1'b0, 1'b0, N, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_bad++;
        $display("FAIL back_to_back cycle %0d: got %b want %b",
                 c, obs, exp_v);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_fin;
    @(negedge clock);
    start = 1'b1; op = 1'b1; b_zero = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    n_cmp++;
    if (busy !== 1'b1 || acc_en !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_iter_busy: got busy=%b acc_en=%b want 1 1",
               busy, acc_en);
    end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_mid_async: got %b want %b", obs, 10'b0);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    saw_fin = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (finished || busy) saw_fin = 1'b1;
      @(negedge clock);
    end
    n_cmp++;
    if (saw_fin !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_no_finish: got activity=%b want 0", saw_fin);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div0();
    test_early_term();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_mul();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
